// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option: define MEM_ARB_FIXED_PRIO_EN for strict port-0 priority
// instead of round-robin arbitration.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way request picker.
// Default: round-robin, the port not granted last wins a tie.
// With MEM_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie and the
// last-grant input is ignored.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // Strict priority: port 0 wins whenever it is asking
  always_comb begin
    grant = req[PORT_CPU] ? PORT_CPU : PORT_LDR;
  end
`else
  // Round-robin: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    if (req == 2'b11) grant = ~last;
    else              grant = req[PORT_LDR] ? PORT_LDR : PORT_CPU;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for the single-port main memory.
// Each transaction runs IDLE -> ACCESS -> WAIT -> DONE; the memory writes on
// the negedge inside ACCESS and presents read data at the posedge ending it.
// Build option: MEM_ARB_FIXED_PRIO_EN selects strict port-0 priority and
// removes the last-grant pointer; FSM timing is identical in both builds.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          we0,
  input  logic          we1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t state;
  logic       gnt;
  logic       last;
  logic       pick_grant;
  logic       pick_valid;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // No pointer in the fixed-priority build; the picker ignores this input.
  assign last = PORT_LDR;
`else
  // Last-grant pointer; resets to port 1 so port 0 takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= PORT_LDR;
    end else if (state == IDLE && pick_valid) begin
      last <= pick_grant;
    end
  end
`endif

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Transaction sequencer: latch the winner, strobe the write, capture data, ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= PORT_CPU;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt       <= pick_grant;
            mem_addr  <= pick_grant ? addr1  : addr0;
            mem_wdata <= pick_grant ? wdata1 : wdata0;
            mem_we    <= pick_grant ? we1    : we0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // The write has happened on the negedge inside this cycle
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // Memory output reflects mem_addr (including a just-written value)
          rdata <= mem_rdata;
          ack0  <= (gnt == PORT_CPU);
          ack1  <= (gnt == PORT_LDR);
          state <= DONE;
        end
        DONE: begin
          // Requests seen here are ignored; they are re-sampled in IDLE
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
